// File: rtl/dus_engine.sv
// Down-up-sample engine: decimates a ROWS x COLS image by FACTOR in both axes
// and re-expands it to full size, one output pixel per cycle.
// Latency: start accepted at cycle 0, first write at cycle 2, ap_done at N+2.
// Backpressure: none; the memories are always ready, so RUN never stalls.
// Ports: clk/rst (async active-low); ap_start/mode in, ap_idle/ap_ready/ap_done
// out; img_* is the single-port source read port, dus_* the destination port.
module dus_engine #(
  parameter int DATA_W = 32,
  parameter int ROWS   = 32,
  parameter int COLS   = 32,
  parameter int FACTOR = 2,
  parameter int ADDR_W = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_start,
  input  logic              mode,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              ap_done,
  output logic [ADDR_W-1:0] img_address0,
  output logic              img_ce0,
  output logic              img_we0,
  output logic [DATA_W-1:0] img_d0,
  input  logic [DATA_W-1:0] img_q0,
  output logic [ADDR_W-1:0] dus_address0,
  output logic              dus_ce0,
  output logic              dus_we0,
  output logic [DATA_W-1:0] dus_d0
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SH  = $clog2(FACTOR);
  localparam int LBN = COLS / FACTOR;
  localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;
  localparam logic [RW-1:0] RMASK = RW'(FACTOR - 1);
  localparam logic [CW-1:0] CMASK = CW'(FACTOR - 1);

  if (FACTOR < 2 || (FACTOR & (FACTOR - 1)) != 0 ||
      (ROWS % FACTOR) != 0 || (COLS % FACTOR) != 0) begin : g_bad_factor
    $error("dus_engine: FACTOR must be a power of 2, >= 2, dividing ROWS and COLS");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [ADDR_W-1:0] idx;
  logic              mode_r;
  logic [ADDR_W-1:0] rd_hold;

  // stage-1 pixel: written to the destination one cycle after it is scanned
  logic              s1_vld;
  logic              s1_smp;
  logic [ADDR_W-1:0] s1_addr;
  logic [LBW-1:0]    s1_lb;

  logic [DATA_W-1:0] lb [LBN];

  logic              issue;
  logic              smp;
  logic              last;
  logic [LBW-1:0]    lb_idx;

  assign issue  = (state == S_RUN);
  assign smp    = ((row & RMASK) == '0) && ((col & CMASK) == '0);
  assign last   = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));
  assign lb_idx = LBW'(col >> SH);

  assign ap_idle  = (state == S_IDLE);
  assign ap_done  = (state == S_DONE);
  assign ap_ready = issue && last;

  // Read address follows the sampled pixel and otherwise holds its last value.
  assign img_ce0      = issue && smp;
  assign img_address0 = img_ce0 ? idx : rd_hold;
  assign img_we0      = 1'b0;
  assign img_d0       = '0;

  assign dus_ce0      = s1_vld;
  assign dus_we0      = s1_vld;
  assign dus_address0 = s1_addr;

  always_comb begin
    dus_d0 = '0;
    if (s1_vld) begin
      if (s1_smp)       dus_d0 = img_q0;
      else if (!mode_r) dus_d0 = lb[s1_lb];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      idx     <= '0;
      mode_r  <= 1'b0;
      rd_hold <= '0;
      s1_vld  <= 1'b0;
      s1_smp  <= 1'b0;
      s1_addr <= '0;
      s1_lb   <= '0;
    end else begin
      rd_hold <= img_address0;
      s1_vld  <= issue;
      if (issue) begin
        s1_smp  <= smp;
        s1_addr <= idx;
        s1_lb   <= lb_idx;
      end
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            mode_r <= mode;
            row    <= '0;
            col    <= '0;
            idx    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (last) begin
            row   <= '0;
            col   <= '0;
            idx   <= '0;
            state <= S_DRAIN;
          end else begin
            idx <= idx + 1'b1;
            if (col == CW'(COLS - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sampled pixels refresh their line-buffer column; the non-sampled pixels
  // that reuse it always come later in raster order.
  always_ff @(posedge clk) begin
    if (s1_vld && s1_smp) lb[s1_lb] <= img_q0;
  end

endmodule

// File: doc/dus_engine.md
Name: dus_engine

Overview:
- Native, parametrised down-up-sample engine. It reads a ROWS x COLS image from a single-port read memory, decimates by FACTOR in both axes, and re-expands to full size. The result goes to a single-port write memory.
- Replaces the fixed 32x32 HLS-generated kernel and keeps its ap_start/ap_done/ap_ready/ap_idle control handshake and its memory port shapes.
- Adds a zero-insert mode and an internal line buffer, so each source sample is read once, at one output pixel per cycle.

Parameters:
- DATA_W, 32, pixel width in bits.
- ROWS, 32, image height.
- COLS, 32, image width.
- FACTOR, 2, decimation factor. Must be a power of 2, at least 2, and divide both ROWS and COLS; elaboration error otherwise.
- ADDR_W, $clog2(ROWS*COLS), memory address width (10 at defaults).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ap_start  in  1  start request; sampled only in IDLE.
- mode  in  1  0 = nearest-neighbour upsample, 1 = zero-insert; latched when start is accepted.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse when the last pixel is scanned.
- ap_done  out  1  one-cycle pulse when the last output write has completed.
- img_address0  out  ADDR_W  source read address.
- img_ce0  out  1  source read enable.
- img_we0  out  1  tied 0.
- img_d0  out  DATA_W  tied 0.
- img_q0  in  DATA_W  read data, valid 1 cycle after img_ce0.
- dus_address0  out  ADDR_W  destination write address.
- dus_ce0  out  1  destination enable.
- dus_we0  out  1  destination write enable.
- dus_d0  out  DATA_W  write data.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counters cleared, line buffer need not be cleared, ap_idle=1, all other outputs 0. Reset mid-run abandons the frame; no write occurs after rst falls.
- States:
  - IDLE: ap_idle=1. If ap_start=1, latch mode, set row i=0 and column j=0, go to RUN.
  - RUN: scans pixels in raster order, one per cycle, N=ROWS*COLS cycles.
  - DRAIN: one cycle.
  - DONE: one cycle, ap_done=1, then go to IDLE.
- ap_start is ignored outside IDLE. A new frame may start at the earliest from IDLE, 1 cycle after DONE.
- Stage 0 (RUN, pixel i,j):
  - A pixel is sampled iff (i mod FACTOR==0) and (j mod FACTOR==0).
  - If sampled: img_ce0=1 and img_address0=i*COLS+j. Otherwise img_ce0=0 and img_address0 holds its previous value.
  - i, j, the sampled flag and the linear index are registered into stage 1.
- Stage 1 (the next cycle, in RUN or DRAIN): dus_ce0=dus_we0=1, dus_address0=i*COLS+j of the stage-1 pixel.
  - Sampled pixel: dus_d0=img_q0, and lb[j/FACTOR] is written with img_q0.
  - Non-sampled pixel, mode 0: dus_d0=lb[j/FACTOR].
  - Non-sampled pixel, mode 1: dus_d0=0.
  - dus_ce0/dus_we0=0 in every other cycle.
- Line buffer lb: COLS/FACTOR entries of DATA_W bits. An entry written in stage 1 is readable by any later stage-1 cycle. The same-column case is excluded by construction, since the sampled pixel always precedes the non-sampled pixels that use it.
- Counters:
  - j wraps COLS-1 to 0 and increments i. The last pixel is i=ROWS-1, j=COLS-1.
  - FACTOR division and modulo use shift and mask only.
- ap_ready pulses in the RUN cycle that issues the last pixel. The state moves to DRAIN, which writes that last pixel.
- Latency: start accepted at cycle 0 → first write at cycle 2 → last write at cycle N+1 → ap_done at cycle N+2.
- Throughput: 1 pixel/cycle. Exactly N writes per frame, each address written once. Exactly (ROWS/FACTOR)*(COLS/FACTOR) reads.

Test Plan:
- ROWS=COLS=4, FACTOR=2, img[k]=k+1, mode=0: dus rows = {1,1,3,3}, {1,1,3,3}, {9,9,11,11}, {9,9,11,11}. Exactly 4 reads, at addresses 0,2,8,10.
- Same image, mode=1: dus rows = {1,0,3,0}, {0,0,0,0}, {9,0,11,0}, {0,0,0,0}.
- Default 32x32, FACTOR=2, start at cycle 0:
  - ap_ready at cycle 1024, ap_done at cycle 1026, exactly 1024 dus writes.
  - ap_idle is 0 from cycle 1 until it returns to 1 at cycle 1027.
- ap_start held high continuously: second frame accepted only after IDLE is re-entered. Toggling mode mid-frame does not change the output.
- rst asserted at pixel 37 of a frame: all outputs 0 (ap_idle=1) immediately. A subsequent start produces a complete correct frame.
- FACTOR=4, 8x8, img[k]=k: output pixel (i,j) = img[(i&~3)*8 + (j&~3)], e.g. pixel (5,6) = 36.
